// File: rtl/bpsk_link_pkg.sv
// Shared helpers for the BPSK/AWGN link: saturating signed add, popcount
// and the antipodal symbol levels of the default configuration.
package bpsk_link_pkg;

    localparam int MAX_W        = 64;
    localparam int DEF_SAMPLE_W = 25;
    localparam int DEF_AMP      = 2**23;

    localparam logic signed [DEF_SAMPLE_W-1:0] SYM_POS = DEF_SAMPLE_W'(DEF_AMP);
    localparam logic signed [DEF_SAMPLE_W-1:0] SYM_NEG = -SYM_POS;

    // Operands arrive sign-extended to MAX_W; the result is clamped to w bits.
    function automatic logic signed [MAX_W-1:0] sat_add(
        input logic signed [MAX_W-1:0] a,
        input logic signed [MAX_W-1:0] b,
        input int                      w
    );
        logic signed [MAX_W-1:0] s;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi)
            sat_add = hi;
        else if (s < lo)
            sat_add = lo;
        else
            sat_add = s;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < MAX_W; i++)
            c = c + 32'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/bpsk_lane.sv
// One BPSK lane: antipodal map, noise add with saturation, hard slice.
// All three stage registers advance together under the link's global enable.
module bpsk_lane
    import bpsk_link_pkg::*;
#(
    parameter int SAMPLE_W = 25,
    parameter int NOISE_W  = 24,
    parameter int AMP      = 2**23
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               adv_i,
    input  logic               bit_i,
    input  logic [NOISE_W-1:0] noise_i,
    output logic               bit_o
);

    localparam logic signed [SAMPLE_W-1:0] LVL_POS = SAMPLE_W'(AMP);
    localparam logic signed [SAMPLE_W-1:0] LVL_NEG = -LVL_POS;

    logic signed [SAMPLE_W-1:0] sym_q, sym_d;
    logic signed [SAMPLE_W-1:0] sum_q, sum_d;
    logic signed [NOISE_W-1:0]  noise_q;
    logic                       bit_q, bit_d;

    always_comb begin
        sym_d = bit_i ? LVL_POS : LVL_NEG;
        sum_d = SAMPLE_W'(sat_add(MAX_W'(sym_q), MAX_W'(noise_q), SAMPLE_W));
        // a zero sum decides 1
        bit_d = !sum_q[SAMPLE_W-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_q   <= '0;
            noise_q <= '0;
            sum_q   <= '0;
            bit_q   <= 1'b0;
        end else if (adv_i) begin
            sym_q   <= sym_d;
            noise_q <= noise_i;
            sum_q   <= sum_d;
            bit_q   <= bit_d;
        end
    end

    assign bit_o = bit_q;

endmodule

// File: rtl/bpsk_awgn_link.sv
// Three-stage BPSK tx/AWGN/rx link with valid/ready backpressure.
// Error statistics are built only when BPSK_LINK_STATS_EN is defined.
module bpsk_awgn_link
    import bpsk_link_pkg::*;
#(
    parameter int N_BITS   = 24,
    parameter int SAMPLE_W = 25,
    parameter int NOISE_W  = 24,
    parameter int AMP      = 2**23,
    parameter int CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_BITS-1:0]         data_in,
    input  logic [N_BITS*NOISE_W-1:0] noise_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_BITS-1:0]         data_out,
    output logic [N_BITS-1:0]         tx_ref,
    input  logic                      clr_stats,
    output logic [CNT_W-1:0]          bit_err_cnt,
    output logic [CNT_W-1:0]          word_err_cnt,
    output logic [CNT_W-1:0]          word_cnt
);

    if (AMP <= 0 || longint'(AMP) >= (longint'(1) << (SAMPLE_W - 1))) begin : g_bad_amp
        $error("bpsk_awgn_link: AMP must lie in (0, 2**(SAMPLE_W-1))");
    end
    if (N_BITS > MAX_W || SAMPLE_W >= MAX_W - 1 || NOISE_W >= MAX_W - 1) begin : g_bad_width
        $error("bpsk_awgn_link: widths exceed helper range");
    end
    if (SYM_POS + SYM_NEG != 0) begin : g_bad_levels
        $error("bpsk_awgn_link: default symbol levels are not antipodal");
    end

    logic              adv;
    logic [2:0]        vld_q, vld_d;
    logic [N_BITS-1:0] tx1_q, tx2_q, tx3_q;
    logic [N_BITS-1:0] rx_bits;

    // one enable for every stage: the pipeline moves only when stage 3 can empty
    assign adv      = !vld_q[2] || out_ready;
    assign in_ready = adv;

    always_comb begin
        vld_d = vld_q;
        if (adv)
            vld_d = {vld_q[1:0], in_valid};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            tx1_q <= '0;
            tx2_q <= '0;
            tx3_q <= '0;
        end else begin
            vld_q <= vld_d;
            if (adv) begin
                tx1_q <= data_in;
                tx2_q <= tx1_q;
                tx3_q <= tx2_q;
            end
        end
    end

    for (genvar i = 0; i < N_BITS; i++) begin : g_lane
        bpsk_lane #(
            .SAMPLE_W (SAMPLE_W),
            .NOISE_W  (NOISE_W),
            .AMP      (AMP)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .adv_i   (adv),
            .bit_i   (data_in[i]),
            .noise_i (noise_in[i*NOISE_W +: NOISE_W]),
            .bit_o   (rx_bits[i])
        );
    end

    assign out_valid = vld_q[2];
    assign data_out  = rx_bits;
    assign tx_ref    = tx3_q;

`ifdef BPSK_LINK_STATS_EN
    localparam int PC_W  = $clog2(N_BITS + 1);
    localparam int ACC_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [ACC_W-1:0] CNT_MAX = ACC_W'({CNT_W{1'b1}});

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             pc_vld_q, pc_vld_d;
    logic [CNT_W-1:0] bit_err_q, bit_err_d;
    logic [CNT_W-1:0] word_err_q, word_err_d;
    logic [CNT_W-1:0] word_q, word_d;
    logic [ACC_W-1:0] bit_sum, word_err_sum, word_sum;

    always_comb begin
        pc_d         = PC_W'(popcount(MAX_W'(data_out ^ tx_ref)));
        pc_vld_d     = out_valid && out_ready && !clr_stats;
        bit_sum      = ACC_W'(bit_err_q) + ACC_W'(pc_q);
        word_err_sum = ACC_W'(word_err_q) + ACC_W'(pc_q != '0);
        word_sum     = ACC_W'(word_q) + ACC_W'(1'b1);
        bit_err_d    = bit_err_q;
        word_err_d   = word_err_q;
        word_d       = word_q;
        // a clear also drops the word whose popcount is in flight
        if (clr_stats) begin
            bit_err_d  = '0;
            word_err_d = '0;
            word_d     = '0;
        end else if (pc_vld_q) begin
            bit_err_d  = (bit_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(bit_sum);
            word_err_d = (word_err_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(word_err_sum);
            word_d     = (word_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(word_sum);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            pc_vld_q   <= 1'b0;
            bit_err_q  <= '0;
            word_err_q <= '0;
            word_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            pc_vld_q   <= pc_vld_d;
            bit_err_q  <= bit_err_d;
            word_err_q <= word_err_d;
            word_q     <= word_d;
        end
    end

    assign bit_err_cnt  = bit_err_q;
    assign word_err_cnt = word_err_q;
    assign word_cnt     = word_q;
`else
    logic unused_clr;
    assign unused_clr   = clr_stats;
    assign bit_err_cnt  = '0;
    assign word_err_cnt = '0;
    assign word_cnt     = '0;
`endif

endmodule

// File: tb/tb_bpsk_awgn_link.sv
// Bench for bpsk_awgn_link: directed vector table, backpressure/reset/clear
// sequences and a randomized run against an arithmetic reference model.
`timescale 1ns/1ps
module tb_bpsk_awgn_link;

    localparam int N   = 24;
    localparam int SW  = 25;
    localparam int NW  = 25;
    localparam int AMP = 2**23;
    localparam longint SMAX = (longint'(1) << (SW - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (SW - 1));
    localparam longint MAX32 = (longint'(1) << 32) - 1;
    localparam longint MAX4  = 15;

    logic          clk = 1'b0;
    logic          reset, in_valid, out_ready, clr_stats;
    logic          in_ready, out_valid, in_ready4, out_valid4;
    logic [N-1:0]  data_in, data_out, tx_ref, data_out4, tx_ref4;
    logic [N*NW-1:0] noise_in;
    logic [31:0]   bec, wec, wc;
    logic [3:0]    bec4, wec4, wc4;

    always #5 clk = ~clk;

    bpsk_awgn_link #(.N_BITS(N), .SAMPLE_W(SW), .NOISE_W(NW), .AMP(AMP), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .noise_in(noise_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .tx_ref(tx_ref), .clr_stats(clr_stats),
        .bit_err_cnt(bec), .word_err_cnt(wec), .word_cnt(wc));

    bpsk_awgn_link #(.N_BITS(N), .SAMPLE_W(SW), .NOISE_W(NW), .AMP(AMP), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .data_in(data_in), .noise_in(noise_in), .out_valid(out_valid4), .out_ready(out_ready),
        .data_out(data_out4), .tx_ref(tx_ref4), .clr_stats(clr_stats),
        .bit_err_cnt(bec4), .word_err_cnt(wec4), .word_cnt(wc4));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] ref_rx(input logic [N-1:0] d, input logic [N*NW-1:0] nz);
        logic [N-1:0] r;
        logic signed [NW-1:0] n;
        longint s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            n = nz[i*NW +: NW];
            s = (d[i] ? longint'(AMP) : -longint'(AMP)) + longint'(n);
            if (s > SMAX) s = SMAX;
            if (s < SMIN) s = SMIN;
            r[i] = (s >= 0);
        end
        return r;
    endfunction

    function automatic logic [N*NW-1:0] mk_noise(input longint n0, input longint n5, input longint nr);
        logic [N*NW-1:0] v;
        for (int i = 0; i < N; i++)
            v[i*NW +: NW] = NW'((i == 0) ? n0 : (i == 5) ? n5 : nr);
        return v;
    endfunction

    function automatic longint sat_acc(input longint v, input longint a, input longint mx);
        return (v + a > mx) ? mx : v + a;
    endfunction

    // scoreboard and counter model
    typedef struct { logic [N-1:0] rx; logic [N-1:0] tx; } sb_t;
    sb_t    sb[$];
    sb_t    e;
    bit     xfer, pend, last_acc, stall_prev;
    int     errs, pend_err;
    logic [N-1:0] stall_data, stall_tx;
    longint m_bit = 0, m_werr = 0, m_word = 0, m4_bit = 0, m4_werr = 0, m4_word = 0;

    initial begin
        pend = 0; last_acc = 0; stall_prev = 0; pend_err = 0;
    end

    always @(negedge clk) begin
        xfer = 1'b0;
        errs = 0;
        if (!reset && out_valid && out_ready) begin
            xfer = 1'b1;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected_word: got %0h, expected no word (t=%0t)", data_out, $time);
            end else begin
                e = sb.pop_front();
                check("sb_data_out", data_out, e.rx);
                check("sb_tx_ref", tx_ref, e.tx);
                check("sb_data_out_c4", data_out4, e.rx);
                check("sb_out_valid_c4", out_valid4, 1);
                errs = $countones(e.rx ^ e.tx);
            end
        end
        if (stall_prev) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", data_out, stall_data);
            check("stall_tx", tx_ref, stall_tx);
        end
        stall_prev = !reset && out_valid && !out_ready;
        stall_data = data_out;
        stall_tx   = tx_ref;
`ifdef BPSK_LINK_STATS_EN
        check("bit_err_cnt", bec, m_bit);
        check("word_err_cnt", wec, m_werr);
        check("word_cnt", wc, m_word);
        check("bit_err_cnt_c4", bec4, m4_bit);
        check("word_err_cnt_c4", wec4, m4_werr);
        check("word_cnt_c4", wc4, m4_word);
`else
        check("bit_err_cnt_off", bec, 0);
        check("word_err_cnt_off", wec, 0);
        check("word_cnt_off", wc, 0);
        check("bit_err_cnt_c4_off", bec4, 0);
`endif
        if (reset || clr_stats) begin
            m_bit = 0; m_werr = 0; m_word = 0;
            m4_bit = 0; m4_werr = 0; m4_word = 0;
            pend = 0;
        end else begin
            if (pend) begin
                m_bit   = sat_acc(m_bit, pend_err, MAX32);
                m_werr  = sat_acc(m_werr, (pend_err != 0) ? 1 : 0, MAX32);
                m_word  = sat_acc(m_word, 1, MAX32);
                m4_bit  = sat_acc(m4_bit, pend_err, MAX4);
                m4_werr = sat_acc(m4_werr, (pend_err != 0) ? 1 : 0, MAX4);
                m4_word = sat_acc(m4_word, 1, MAX4);
            end
            pend     = xfer;
            pend_err = errs;
        end
        if (reset)
            sb.delete();
        else if (in_valid && in_ready)
            sb.push_back('{rx: ref_rx(data_in, noise_in), tx: data_in});
        last_acc = !reset && in_valid && in_ready;
    end

    typedef struct {
        logic [N-1:0] data;
        longint       n0;
        longint       n5;
        longint       nr;
        logic [N-1:0] exp;
    } vec_t;
    localparam int NV = 13;
    vec_t vecs[NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_noise();
        for (int i = 0; i < N; i++)
            noise_in[i*NW +: NW] = NW'($urandom);
    endtask

    task automatic new_word();
        data_in = N'($urandom);
        rnd_noise();
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_stats = 1'b0;
        @(negedge clk);
        while (sb.size() != 0 && k < 30) begin
            tick();
            @(negedge clk);
            k++;
        end
        check(name, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{24'hA5A5A5, 0, 0, 0, 24'hA5A5A5};
        vecs[1]  = '{24'h000000, 0, 0, 0, 24'h000000};
        vecs[2]  = '{24'hFFFFFF, 0, 0, 0, 24'hFFFFFF};
        vecs[3]  = '{24'h000001, -(2**23) - 1, 0, 0, 24'h000000};
        vecs[4]  = '{24'h000001, -(2**23), 0, 0, 24'h000001};
        vecs[5]  = '{24'h000020, 0, 2**23 - 1, 0, 24'h000020};
        vecs[6]  = '{24'h000000, 0, 2**23 - 1, 0, 24'h000000};
        vecs[7]  = '{24'h000020, 0, 2**24 - 1, 0, 24'h000020};
        vecs[8]  = '{24'h000000, 0, -(2**24), 0, 24'h000000};
        vecs[9]  = '{24'hFFFFFF, -(2**23), -(2**23), -(2**23), 24'hFFFFFF};
        vecs[10] = '{24'hFFFFFF, -(2**23) - 1, -(2**23) - 1, -(2**23) - 1, 24'h000000};
        vecs[11] = '{24'h5A5A5A, 2**23 - 1, 2**23 - 1, 2**23 - 1, 24'h5A5A5A};
        vecs[12] = '{24'h000000, 2**23 - 1, 0, 0, 24'h000000};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_stats = 1'b0;
        data_in = '0; noise_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_data_out", data_out, 0);
        check("rst_tx_ref", tx_ref, 0);

        // back-to-back table, each output exactly 3 cycles after its input
        for (int i = 0; i < NV + 3; i++) begin
            tick();
            if (i < NV) begin
                in_valid = 1'b1;
                data_in  = vecs[i].data;
                noise_in = mk_noise(vecs[i].n0, vecs[i].n5, vecs[i].nr);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i >= 3) begin
                check($sformatf("vec%0d_valid", i - 3), out_valid, 1);
                check($sformatf("vec%0d_data_out", i - 3), data_out, vecs[i - 3].exp);
                check($sformatf("vec%0d_tx_ref", i - 3), tx_ref, vecs[i - 3].data);
            end else begin
                check($sformatf("latency_idle%0d", i), out_valid, 0);
            end
        end
        repeat (3) begin tick(); @(negedge clk); end
`ifdef BPSK_LINK_STATS_EN
        check("tbl_bit_err", bec, 25);
        check("tbl_word_err", wec, 2);
        check("tbl_words", wc, NV);
        check("tbl_bit_err_c4_sat", bec4, 15);
        check("tbl_words_c4", wc4, NV);
`endif

        // clear coinciding with an output transfer of a 24-error word
        tick();
        in_valid = 1'b1;
        data_in  = vecs[10].data;
        noise_in = mk_noise(vecs[10].n0, vecs[10].n5, vecs[10].nr);
        @(negedge clk);
        tick(); in_valid = 1'b0; @(negedge clk);
        tick(); @(negedge clk);
        tick(); clr_stats = 1'b1; @(negedge clk);
        check("clr_coincide_valid", out_valid, 1);
        tick(); clr_stats = 1'b0; @(negedge clk);
        tick(); @(negedge clk);
`ifdef BPSK_LINK_STATS_EN
        check("clr_bit_err", bec, 0);
        check("clr_word_err", wec, 0);
        check("clr_words", wc, 0);
        check("clr_bit_err_c4", bec4, 0);
`endif

        // backpressure: fill, stall, release
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        new_word();
        @(negedge clk);
        check("bp_in_ready0", in_ready, 1);
        for (int k = 1; k < 7; k++) begin
            tick();
            if (last_acc) new_word();
            @(negedge clk);
            check($sformatf("bp_in_ready%0d", k), in_ready, (k < 3) ? 1 : 0);
            check($sformatf("bp_in_ready_c4_%0d", k), in_ready4, (k < 3) ? 1 : 0);
            if (k >= 3) check($sformatf("bp_out_valid%0d", k), out_valid, 1);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            out_ready = 1'b1;
            if (last_acc) new_word();
            @(negedge clk);
            check($sformatf("bp_stream_ready%0d", k), in_ready, 1);
        end
        drain("bp_drain");

        // reset with two words in flight
        tick(); in_valid = 1'b1; new_word(); @(negedge clk);
        tick(); if (last_acc) new_word(); @(negedge clk);
        tick(); reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; @(negedge clk);
        tick(); reset = 1'b0; @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_bit_err", bec, 0);
        check("midrst_words", wc, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            out_ready = 1'b1;
            @(negedge clk);
            check($sformatf("midrst_no_stale%0d", k), out_valid, 0);
        end

        // randomized traffic with random backpressure and clears
        for (int k = 0; k < 400; k++) begin
            tick();
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                data_in  = N'($urandom);
            end
            rnd_noise();
            out_ready = ($urandom_range(0, 3) != 0);
            clr_stats = ($urandom_range(0, 31) == 0);
            @(negedge clk);
        end
        drain("rnd_drain");
        repeat (3) begin tick(); @(negedge clk); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
